// File: rtl/spi_pkg.sv
// Shared constants and bit-order helpers for the SPI slave.
package spi_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_SHIFT = 2'd2;

  localparam logic [7:0] IDLE_FILL   = 8'hFF;
  localparam int         SYNC_STAGES = 2;

  function automatic logic first_bit(input logic [7:0] b, input logic msb);
    return msb ? b[7] : b[0];
  endfunction

  // Vacated positions fill with 1 so a short shift never drives stale data.
  function automatic logic [7:0] tx_shift(input logic [7:0] b, input logic msb);
    return msb ? {b[6:0], 1'b1} : {1'b1, b[7:1]};
  endfunction

  function automatic logic [7:0] rx_shift(input logic [7:0] b, input logic d, input logic msb);
    return msb ? {b[6:0], d} : {d, b[7:1]};
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, with a selectable reset level.
module spi_sync
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0,
  parameter int   STAGES  = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r <= {STAGES{RST_VAL}};
    else     r <= {r[STAGES-2:0], d};
  end

  assign q = r[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, oversampled by clk, with a one-byte transmit holding register.
// state    | meaning
// ST_IDLE  | ss high, dout parked at 1
// ST_LOAD  | one cycle: holding register -> tx shifter, first bit onto dout
// ST_SHIFT | receiving/transmitting bits on sck edges
module spi_slave
  import spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       mlb,
  input  logic       ss,
  input  logic       sck,
  input  logic       din,
  output logic       dout,
  input  logic [7:0] tdat,
  input  logic       tload,
  output logic       tready,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic       underrun
);

  logic ss_s, sck_s, din_s;
  logic ss_q, sck_q;
  logic ss_fall, ss_rise, sck_rise, sck_fall;

  spi_sync #(.RST_VAL(1'b1)) u_sync_ss  (.clk(clk), .rst(rst), .d(ss),  .q(ss_s));
  spi_sync #(.RST_VAL(1'b0)) u_sync_sck (.clk(clk), .rst(rst), .d(sck), .q(sck_s));
  spi_sync #(.RST_VAL(1'b1)) u_sync_din (.clk(clk), .rst(rst), .d(din), .q(din_s));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_q  <= 1'b1;
      sck_q <= 1'b0;
    end else begin
      ss_q  <= ss_s;
      sck_q <= sck_s;
    end
  end

  assign ss_fall  =  ss_q  & ~ss_s;
  assign ss_rise  = ~ss_q  &  ss_s;
  assign sck_rise = ~sck_q &  sck_s;
  assign sck_fall =  sck_q & ~sck_s;

  state_t     state;
  logic       mlb_q;
  logic [7:0] hold, tx, rx;
  logic [3:0] cnt;
  logic       load_xfer, tload_ok;
  logic [7:0] load_src, tx_nxt;

  // A LOAD that empties the holding register may be refilled in the same cycle.
  assign load_xfer = (state == ST_LOAD) && !ss_rise && !tready;
  assign tload_ok  = tload && (tready || load_xfer);
  assign load_src  = tready ? IDLE_FILL : hold;
  assign tx_nxt    = tx_shift(tx, mlb_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold   <= IDLE_FILL;
      tready <= 1'b1;
    end else if (tload_ok) begin
      hold   <= tdat;
      tready <= 1'b0;
    end else if (load_xfer) begin
      tready <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      mlb_q    <= 1'b0;
      tx       <= IDLE_FILL;
      rx       <= IDLE_FILL;
      cnt      <= 4'd0;
      dout     <= 1'b1;
      rdata    <= 8'h00;
      rvalid   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      rvalid   <= 1'b0;
      underrun <= 1'b0;
      if (ss_rise) begin
        state <= ST_IDLE;
        dout  <= 1'b1;
        cnt   <= 4'd0;
        tx    <= IDLE_FILL;
        rx    <= IDLE_FILL;
      end else begin
        case (state)
          ST_IDLE: begin
            if (ss_fall) begin
              mlb_q <= mlb;
              state <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            tx       <= load_src;
            dout     <= first_bit(load_src, mlb_q);
            underrun <= tready;
            state    <= ST_SHIFT;
          end
          ST_SHIFT: begin
            if (cnt == 4'd8) begin
              rdata  <= rx;
              rvalid <= 1'b1;
              cnt    <= 4'd0;
            end else if (sck_rise) begin
              rx  <= rx_shift(rx, din_s, mlb_q);
              cnt <= cnt + 4'd1;
            end else if (sck_fall) begin
              // A fall with the counter cleared follows a completed byte.
              if (cnt == 4'd0) begin
                state <= ST_LOAD;
              end else begin
                tx   <= tx_nxt;
                dout <= first_bit(tx_nxt, mlb_q);
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: bit-banged mode-0 master plus byte-level expectation model.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst, mlb, ss, sck, din, tload;
  logic [7:0] tdat;
  logic       dout, tready, rvalid, underrun;
  logic [7:0] rdata;

  always #5 clk = ~clk;

  spi_slave dut (
    .clk(clk), .rst(rst), .mlb(mlb), .ss(ss), .sck(sck), .din(din),
    .dout(dout), .tdat(tdat), .tload(tload), .tready(tready),
    .rdata(rdata), .rvalid(rvalid), .underrun(underrun)
  );

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log every rvalid pulse and count underrun pulses.
  int         rv_cnt = 0;
  int         ur_cnt = 0;
  int         rv_cyc = 0;
  logic [7:0] rv_log [256];
  always @(negedge clk) begin
    if (rvalid) begin
      rv_log[rv_cnt[7:0]] <= rdata;
      rv_cnt <= rv_cnt + 1;
      rv_cyc <= cyc;
    end
    if (underrun) ur_cnt <= ur_cnt + 1;
  end

  logic [7:0] m_tx [4];
  logic [7:0] m_rx [4];
  logic [7:0] f_dat [4];
  bit         f_v [4];
  int         rise8_cyc;
  logic [7:0] last_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] d);
    tdat = d; tload = 1'b1; wait_n(1);
    tload = 1'b0; wait_n(2);
  endtask

  // Master: nb bytes at half-period hp; cut>0 stops after that many rises of byte 0.
  task automatic master(input int nb, input int hp, input int cut);
    logic [7:0] r;
    int idx;
    ss = 1'b0;
    wait_n(hp);
    for (int b = 0; b < nb; b++) begin
      r = 8'h00;
      for (int i = 0; i < 8; i++) begin
        idx = mlb ? 7 - i : i;
        din = m_tx[b][idx];
        if (i == 2 && f_v[b]) begin
          tdat = f_dat[b]; tload = 1'b1; wait_n(1);
          tload = 1'b0; wait_n(hp - 1);
        end else begin
          wait_n(hp);
        end
        sck = 1'b1;
        r[idx] = dout;
        if (i == 7) rise8_cyc = cyc;
        if (cut > 0 && i + 1 == cut) return;
        wait_n(hp);
        if (b == nb - 1 && i == 7) ss = 1'b1;
        sck = 1'b0;
      end
      m_rx[b] = r;
    end
    din = 1'b1;
    wait_n(4 * hp);
  endtask

  // Expected: byte 0 returns the preload, byte k the value fed during byte k-1, FF when none.
  task automatic run_check(input string tag, input int nb, input int hp,
                           input bit pre_v, input logic [7:0] pre_d);
    int rv0, ur0, exp_ur;
    bit empty;
    logic [7:0] em;
    if (pre_v) preload(pre_d);
    rv0 = rv_cnt; ur0 = ur_cnt; exp_ur = 0;
    master(nb, hp, 0);
    for (int b = 0; b < nb; b++) begin
      empty = (b == 0) ? !pre_v : !f_v[b-1];
      em = empty ? 8'hFF : ((b == 0) ? pre_d : f_dat[b-1]);
      if (empty) exp_ur++;
      chk({tag, "_miso"}, m_rx[b], em);
      chk({tag, "_rlog"}, rv_log[8'(rv0 + b)], m_tx[b]);
    end
    chk({tag, "_nrvalid"}, rv_cnt - rv0, nb);
    chk({tag, "_nunder"}, ur_cnt - ur0, exp_ur);
    chk({tag, "_rdata"}, rdata, m_tx[nb-1]);
    chk({tag, "_tready"}, tready, 1'b1);
    chk({tag, "_dout_idle"}, dout, 1'b1);
    last_exp = m_tx[nb-1];
  endtask

  task automatic clear_feeds();
    for (int k = 0; k < 4; k++) begin f_v[k] = 0; f_dat[k] = 8'h00; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rv0, ur0, nb, hp;
    rst = 1'b1; ss = 1'b1; sck = 1'b0; din = 1'b1; mlb = 1'b1;
    tload = 1'b0; tdat = 8'h00;
    clear_feeds();
    wait_n(3);
    chk("rst_dout", dout, 1'b1);
    chk("rst_tready", tready, 1'b1);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    rst = 1'b0;
    wait_n(3);

    // MSB first, 3C out / A5 back; rvalid 3 clk after the sampling edge that follows the drive.
    mlb = 1'b1; m_tx[0] = 8'h3C;
    run_check("msb", 1, 8, 1, 8'hA5);
    chk("msb_latency", rv_cyc - rise8_cyc, 1 + 3);

    mlb = 1'b0; m_tx[0] = 8'h80;
    run_check("lsb", 1, 8, 1, 8'h01);

    mlb = 1'b1; m_tx[0] = 8'h96; m_tx[1] = 8'h4B;
    f_v[0] = 1; f_dat[0] = 8'hD2;
    run_check("two", 2, 8, 1, 8'h17);
    clear_feeds();

    mlb = 1'b0; m_tx[0] = 8'h6E;
    run_check("under", 1, 8, 0, 8'h00);

    // ss raised after 4 rises: partial byte discarded.
    mlb = 1'b1; m_tx[0] = 8'hF0;
    preload(8'h77);
    rv0 = rv_cnt; ur0 = ur_cnt;
    master(1, 8, 4);
    wait_n(8);
    sck = 1'b0; ss = 1'b1; din = 1'b1;
    wait_n(10);
    chk("abort_nrvalid", rv_cnt - rv0, 0);
    chk("abort_nunder", ur_cnt - ur0, 0);
    chk("abort_dout", dout, 1'b1);
    chk("abort_rdata", rdata, last_exp);
    m_tx[0] = 8'h5A;
    run_check("after_abort", 1, 8, 1, 8'hC8);

    // Reset after 5 bits.
    mlb = 1'b0; m_tx[0] = 8'h0F;
    preload(8'h33);
    rv0 = rv_cnt;
    master(1, 8, 5);
    wait_n(3);
    rst = 1'b1; ss = 1'b1; sck = 1'b0; din = 1'b1;
    #1;
    chk("mrst_dout", dout, 1'b1);
    chk("mrst_tready", tready, 1'b1);
    chk("mrst_rdata", rdata, 8'h00);
    chk("mrst_rvalid", rvalid, 1'b0);
    chk("mrst_underrun", underrun, 1'b0);
    wait_n(2);
    rst = 1'b0;
    wait_n(4);
    chk("mrst_nrvalid", rv_cnt - rv0, 0);
    m_tx[0] = 8'hC3;
    run_check("after_rst", 1, 8, 1, 8'h9A);

    // Randomized transfers: order, length, speed, and which slots get loaded.
    for (int t = 0; t < 8; t++) begin
      mlb = 1'($urandom_range(0, 1));
      nb  = $urandom_range(1, 3);
      hp  = $urandom_range(8, 11);
      clear_feeds();
      for (int b = 0; b < nb; b++) begin
        m_tx[b] = 8'($urandom);
        if (b < nb - 1) begin
          f_v[b]   = ($urandom_range(0, 3) != 0);
          f_dat[b] = 8'($urandom);
        end
      end
      run_check("rand", nb, hp, ($urandom_range(0, 3) != 0), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
